// File: rtl/pipe_front_ctl_pkg.sv
// Shared definitions for the front-end pipeline register block.
//   NOP_INSTR : encoding loaded into IF/ID on a flush (sll $0,$0,0)
//   PC_STEP   : sequential fetch increment
//   state_e   : front-end FSM states
//   if_id_t   : IF/ID register contents
package pipe_front_ctl_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/pipe_front_ctl_if.sv
// Hazard-control / fetch bus between the hazard unit (master) and the
// front-end register block (slave).
//   master drives : PCWrite, IFWrite, IFflush, ctrflush, Branch_1, PCSrc, Jump,
//                   br_target, j_target, imem_instr, id_ctrl
//   slave drives  : pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_ctrl,
//                   id_ex_valid, stall_cnt, flush_cnt, stall_timeout
interface pipe_front_ctl_if #(
   parameter int CTRL_W = 10
) ();

   logic              PCWrite;
   logic              IFWrite;
   logic              IFflush;
   logic              ctrflush;
   logic              Branch_1;
   logic              PCSrc;
   logic              Jump;
   logic [31:0]       br_target;
   logic [31:0]       j_target;
   logic [31:0]       imem_instr;
   logic [CTRL_W-1:0] id_ctrl;

   logic [31:0]       pc;
   logic [31:0]       if_id_instr;
   logic [31:0]       if_id_pc4;
   logic              if_id_valid;
   logic [CTRL_W-1:0] id_ex_ctrl;
   logic              id_ex_valid;
   logic [15:0]       stall_cnt;
   logic [15:0]       flush_cnt;
   logic              stall_timeout;

   modport master (
      output PCWrite, IFWrite, IFflush, ctrflush, Branch_1, PCSrc, Jump,
             br_target, j_target, imem_instr, id_ctrl,
      input  pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_ctrl,
             id_ex_valid, stall_cnt, flush_cnt, stall_timeout
   );

   modport slave (
      input  PCWrite, IFWrite, IFflush, ctrflush, Branch_1, PCSrc, Jump,
             br_target, j_target, imem_instr, id_ctrl,
      output pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_ctrl,
             id_ex_valid, stall_cnt, flush_cnt, stall_timeout
   );

endinterface

// File: rtl/pipe_front_ctl_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   clk   : clock
//   rst_n : synchronous active-low reset (clears to 0)
//   en_i  : count this cycle
//   cnt_o : current count
module sat_counter16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_front_ctl.sv
// Front-end pipeline registers of the 5-stage core: PC, IF/ID and the control
// half of ID/EX. Applies the hazard unit's stall/flush orders, keeps stall and
// flush statistics and a sticky watchdog for over-long stall runs.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pipe_front_ctl_if slave (hazard controls, fetch/decode data in;
//                pipeline registers and debug counters out)
module pipe_front_ctl
   import pipe_front_ctl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CTRL_W    = 10,
   parameter int          STALL_MAX = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pipe_front_ctl_if.slave bus
);

   localparam int                RUN_W   = $clog2(STALL_MAX + 2);
   localparam logic [RUN_W-1:0]  RUN_LIM = RUN_W'(STALL_MAX);
   localparam logic [RUN_W-1:0]  RUN_SAT = RUN_W'(STALL_MAX + 1);

   state_e            state_q;
   logic [31:0]       pc_q, pc_d, pc_plus4, pc_next;
   if_id_t            if_id_q, if_id_d;
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic              ex_valid_q, ex_valid_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              tmo_q, tmo_d;
   logic              boot;
   logic [15:0]       stall_cnt, flush_cnt;

   assign boot     = (state_q == BOOT);
   assign pc_plus4 = pc_q + PC_STEP;   // wraps mod 2^32

   always_comb begin
      // Branch only counts when its decision is valid; it then beats a jump.
      pc_next = pc_plus4;
      if (bus.PCSrc && bus.Branch_1) pc_next = bus.br_target;
      else if (bus.Jump)             pc_next = bus.j_target;

      pc_d = pc_q;
      if (bus.PCWrite && !boot) pc_d = pc_next;

      // Flush wins over a simultaneous stall.
      if_id_d = if_id_q;
      if (bus.IFflush)                 if_id_d = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
      else if (bus.IFWrite && !boot)   if_id_d = '{instr: bus.imem_instr, pc4: pc_plus4, valid: 1'b1};

      // ID/EX is never held: a stalled decode still advances as a bubble
      // because the hazard unit pairs stalls with ctrflush.
      ex_ctrl_d  = bus.id_ctrl;
      ex_valid_d = if_id_q.valid;
      if (bus.ctrflush) begin
         ex_ctrl_d  = '0;
         ex_valid_d = 1'b0;
      end

      // Length of the current stall run; parks one past the limit so it
      // cannot wrap back under it.
      run_d = '0;
      if (!boot && !bus.IFWrite) run_d = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;

      tmo_d = tmo_q | (run_d > RUN_LIM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         if_id_q    <= '0;
         ex_ctrl_q  <= '0;
         ex_valid_q <= 1'b0;
         run_q      <= '0;
         tmo_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if_id_q    <= if_id_d;
         ex_ctrl_q  <= ex_ctrl_d;
         ex_valid_q <= ex_valid_d;
         run_q      <= run_d;
         tmo_q      <= tmo_d;
         case (state_q)
            BOOT:    state_q <= RUN;
            RUN:     if (!bus.IFWrite) state_q <= STALL;
            STALL:   if (bus.IFWrite)  state_q <= RUN;
            default: state_q <= BOOT;
         endcase
      end
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (!boot && !bus.IFWrite),
      .cnt_o (stall_cnt)
   );

   // A cycle with both flushes is one flush event.
   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (bus.IFflush || bus.ctrflush),
      .cnt_o (flush_cnt)
   );

   assign bus.pc            = pc_q;
   assign bus.if_id_instr   = if_id_q.instr;
   assign bus.if_id_pc4     = if_id_q.pc4;
   assign bus.if_id_valid   = if_id_q.valid;
   assign bus.id_ex_ctrl    = ex_ctrl_q;
   assign bus.id_ex_valid   = ex_valid_q;
   assign bus.stall_cnt     = stall_cnt;
   assign bus.flush_cnt     = flush_cnt;
   assign bus.stall_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_front_ctl.sv
module tb_pipe_front_ctl;

   localparam int CW   = 10;
   localparam int SMAX = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_front_ctl_if #(.CTRL_W(CW)) bus ();

   pipe_front_ctl #(
      .RESET_PC  (32'h0000_0000),
      .CTRL_W    (CW),
      .STALL_MAX (SMAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 25) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what each visible register must hold after every edge.
   logic [31:0]   m_pc, m_instr, m_pc4;
   logic          m_iv, m_ev, m_to;
   logic [CW-1:0] m_ctrl;
   int            m_scnt, m_fcnt, m_since, m_run;

   always @(posedge clk) begin : model
      bit          boot;
      logic [31:0] tgt, old_pc;
      logic        old_iv;
      if (!rst_n) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_iv = 1'b0;
         m_ctrl = '0; m_ev = 1'b0; m_scnt = 0; m_fcnt = 0; m_to = 1'b0;
         m_since = 0; m_run = 0;
      end else begin
         boot    = (m_since == 0);
         if (m_since < 10) m_since++;
         old_pc  = m_pc;
         old_iv  = m_iv;
         if (bus.PCSrc && bus.Branch_1) tgt = bus.br_target;
         else if (bus.Jump)             tgt = bus.j_target;
         else                           tgt = old_pc + 32'd4;
         if (bus.PCWrite && !boot) m_pc = tgt;
         if (bus.ctrflush) begin m_ctrl = '0; m_ev = 1'b0; end
         else              begin m_ctrl = bus.id_ctrl; m_ev = old_iv; end
         if (bus.IFflush) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_iv = 1'b0;
         end else if (bus.IFWrite && !boot) begin
            m_instr = bus.imem_instr; m_pc4 = old_pc + 32'd4; m_iv = 1'b1;
         end
         if (!boot && !bus.IFWrite && m_scnt < 65535) m_scnt++;
         if ((bus.IFflush || bus.ctrflush) && m_fcnt < 65535) m_fcnt++;
         if (!boot && !bus.IFWrite) m_run++; else m_run = 0;
         if (m_run > SMAX) m_to = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", bus.pc, m_pc);
         chk("if_id_instr", bus.if_id_instr, m_instr);
         chk("if_id_pc4", bus.if_id_pc4, m_pc4);
         chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_iv));
         chk("id_ex_ctrl", 32'(bus.id_ex_ctrl), 32'(m_ctrl));
         chk("id_ex_valid", 32'(bus.id_ex_valid), 32'(m_ev));
         chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_scnt));
         chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fcnt));
         chk("stall_timeout", 32'(bus.stall_timeout), 32'(m_to));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.PCWrite = 1'b1; bus.IFWrite = 1'b1; bus.IFflush = 1'b0; bus.ctrflush = 1'b0;
      bus.Branch_1 = 1'b0; bus.PCSrc = 1'b0; bus.Jump = 1'b0;
      bus.br_target = 32'h0; bus.j_target = 32'h0;
      bus.imem_instr = 32'h2008_0005;
      bus.id_ctrl = CW'($urandom_range(1, (1 << CW) - 1));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pc"}, bus.pc, 32'h0);
      chk({tag, ".instr"}, bus.if_id_instr, 32'h0);
      chk({tag, ".pc4"}, bus.if_id_pc4, 32'h0);
      chk({tag, ".iv"}, 32'(bus.if_id_valid), 32'h0);
      chk({tag, ".ctrl"}, 32'(bus.id_ex_ctrl), 32'h0);
      chk({tag, ".ev"}, 32'(bus.id_ex_valid), 32'h0);
      chk({tag, ".scnt"}, 32'(bus.stall_cnt), 32'h0);
      chk({tag, ".fcnt"}, 32'(bus.flush_cnt), 32'h0);
      chk({tag, ".to"}, 32'(bus.stall_timeout), 32'h0);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk_reset("reset");

      // Boot then straight-line fetch.
      rst_n = 1'b1;
      tick();
      chk("boot.pc", bus.pc, 32'h0);
      chk("boot.iv", 32'(bus.if_id_valid), 32'h0);
      tick();
      chk("run1.pc", bus.pc, 32'h4);
      chk("run1.iv", 32'(bus.if_id_valid), 32'h1);
      chk("run1.pc4", bus.if_id_pc4, 32'h4);
      chk("run1.instr", bus.if_id_instr, 32'h2008_0005);
      tick();
      chk("run2.pc", bus.pc, 32'h8);

      // Three-cycle stall with bubble.
      bus.PCWrite = 1'b0; bus.IFWrite = 1'b0; bus.ctrflush = 1'b1;
      repeat (3) tick();
      chk("stall.pc", bus.pc, 32'h8);
      chk("stall.pc4", bus.if_id_pc4, 32'h8);
      chk("stall.ctrl", 32'(bus.id_ex_ctrl), 32'h0);
      chk("stall.scnt", 32'(bus.stall_cnt), 32'd3);
      chk("stall.fcnt", 32'(bus.flush_cnt), 32'd3);
      chk("stall.to", 32'(bus.stall_timeout), 32'h0);

      // Taken branch with IF flush, then branch not yet valid.
      idle();
      bus.PCSrc = 1'b1; bus.Branch_1 = 1'b1; bus.IFflush = 1'b1; bus.br_target = 32'h40;
      tick();
      chk("br.pc", bus.pc, 32'h40);
      chk("br.instr", bus.if_id_instr, 32'h0);
      chk("br.iv", 32'(bus.if_id_valid), 32'h0);
      bus.Branch_1 = 1'b0; bus.IFflush = 1'b0;
      tick();
      chk("brinv.pc", bus.pc, 32'h44);

      // Branch beats jump.
      bus.Branch_1 = 1'b1; bus.Jump = 1'b1; bus.br_target = 32'h80; bus.j_target = 32'hC0;
      tick();
      chk("brj.pc", bus.pc, 32'h80);

      // PC wrap.
      idle();
      bus.Jump = 1'b1; bus.j_target = 32'hFFFF_FFFC;
      tick();
      chk("jmp.pc", bus.pc, 32'hFFFF_FFFC);
      bus.Jump = 1'b0;
      tick();
      chk("wrap.pc", bus.pc, 32'h0);
      chk("wrap.pc4", bus.if_id_pc4, 32'h0);

      // Watchdog: 4 stall cycles legal, the 5th trips it; sticky until reset.
      bus.IFWrite = 1'b0;
      repeat (4) tick();
      chk("wd4.to", 32'(bus.stall_timeout), 32'h0);
      tick();
      chk("wd5.to", 32'(bus.stall_timeout), 32'h1);
      bus.IFWrite = 1'b1;
      repeat (2) tick();
      chk("wdhold.to", 32'(bus.stall_timeout), 32'h1);
      rst_n = 1'b0;
      tick();
      chk_reset("wdrst");
      rst_n = 1'b1;

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         rst_n         = ($urandom_range(0, 249) != 0);
         bus.PCWrite   = ($urandom_range(0, 3) != 0);
         bus.IFWrite   = ($urandom_range(0, 3) != 0);
         bus.IFflush   = ($urandom_range(0, 5) == 0);
         bus.ctrflush  = ($urandom_range(0, 5) == 0);
         bus.Branch_1  = ($urandom_range(0, 3) == 0);
         bus.PCSrc     = ($urandom_range(0, 1) == 0);
         bus.Jump      = ($urandom_range(0, 4) == 0);
         bus.br_target = $urandom() & 32'hFFFF_FFFC;
         bus.j_target  = $urandom() & 32'hFFFF_FFFC;
         bus.imem_instr = $urandom();
         bus.id_ctrl   = CW'($urandom());
         tick();
      end

      // Stall-count saturation, then reset in the middle of the stall.
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.PCWrite = 1'b0; bus.IFWrite = 1'b0;
      repeat (65540) tick();
      chk("sat.scnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
      chk("sat.to", 32'(bus.stall_timeout), 32'h1);
      rst_n = 1'b0;
      tick();
      chk_reset("midrst");

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
